alu_mul_ctrl: RTL and testbench

//  Sequencer for the ALU fixed-latency multiplier. Sits between the decode->ALU request path and the ALU->D$ request path.

---
 rtl/alu_mul_ctrl_if.sv | 34 +++
 rtl/alu_mul_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_mul_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_ctrl_if.sv
// Request/response bundle between decode, the MUL sequencer and the D$ stage.
// The slave modport is the sequencer's view; master is the surrounding pipeline's view.
interface alu_mul_ctrl_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PC_WIDTH       = 32
);
    logic                      mul_req_valid;
    logic                      mul_req_ready;
    logic [DATA_WIDTH-1:0]     mul_ra_data;
    logic [DATA_WIDTH-1:0]     mul_rb_data;
    logic [REG_ADDR_WIDTH-1:0] mul_rd_addr;
    logic [PC_WIDTH-1:0]       mul_pc;
    logic                      flush;
    logic                      rsp_ready;
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_data;
    logic                      rsp_overflow;
    logic [REG_ADDR_WIDTH-1:0] rsp_dst_reg;
    logic [PC_WIDTH-1:0]       rsp_pc;
    logic                      alu_busy;

    modport slave (
        input  mul_req_valid, mul_ra_data, mul_rb_data, mul_rd_addr, mul_pc,
        input  flush, rsp_ready,
        output mul_req_ready, rsp_valid, rsp_data, rsp_overflow, rsp_dst_reg, rsp_pc, alu_busy
    );

    modport master (
        output mul_req_valid, mul_ra_data, mul_rb_data, mul_rd_addr, mul_pc,
        output flush, rsp_ready,
        input  mul_req_ready, rsp_valid, rsp_data, rsp_overflow, rsp_dst_reg, rsp_pc, alu_busy
    );
endinterface

// File: rtl/alu_mul_ctrl.sv
// Fixed-latency multiplier sequencer: accepts one MUL, stays busy MUL_LATENCY cycles,
// then holds the truncated product for the D$ stage until it is taken or flushed.
module alu_mul_ctrl #(
    parameter int MUL_LATENCY    = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PC_WIDTH       = 32,
    parameter int CNT_WIDTH      = 3
) (
    input  logic          clock,
    input  logic          reset,
    alu_mul_ctrl_if.slave bus
);
    if (MUL_LATENCY < 2) begin : g_bad_lat
        $error("alu_mul_ctrl: MUL_LATENCY must be >= 2");
    end
    if ((2 ** CNT_WIDTH) <= MUL_LATENCY) begin : g_bad_cnt
        $error("alu_mul_ctrl: CNT_WIDTH too narrow for MUL_LATENCY");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MUL_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     ra;
        logic [DATA_WIDTH-1:0]     rb;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [PC_WIDTH-1:0]       pc;
    } req_t;

    logic [1:0]              state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    req_t                    req_q, req_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    ovf_q, ovf_d;
    logic                    accept;
    logic [2*DATA_WIDTH-1:0] prod;

    // Ready is a function of state, flush and rsp_ready only, so decode can use it without a loop through valid.
    assign bus.mul_req_ready = !bus.flush &&
                               ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.rsp_ready));
    assign accept = bus.mul_req_valid && bus.mul_req_ready;

    assign prod = {{DATA_WIDTH{1'b0}}, req_q.ra} * {{DATA_WIDTH{1'b0}}, req_q.rb};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        data_d  = data_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_ONE;
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    data_d  = prod[DATA_WIDTH-1:0];
                    ovf_d   = |prod[2*DATA_WIDTH-1:DATA_WIDTH];
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                if (accept) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_ONE;
                end else if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            req_d.ra = bus.mul_ra_data;
            req_d.rb = bus.mul_rb_data;
            req_d.rd = bus.mul_rd_addr;
            req_d.pc = bus.mul_pc;
        end

        // Accept is already blocked by flush, so only the state and counter need overriding.
        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.rsp_valid    = (state_q == S_DONE);
    assign bus.alu_busy     = (state_q != S_IDLE);
    assign bus.rsp_data     = data_q;
    assign bus.rsp_overflow = ovf_q;
    assign bus.rsp_dst_reg  = req_q.rd;
    assign bus.rsp_pc       = req_q.pc;
endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Directed and randomized checks of alu_mul_ctrl against a transaction-level multiply model.
module tb_alu_mul_ctrl;
    localparam int L  = 4;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int PW = 32;
    localparam int CW = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    alu_mul_ctrl_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .PC_WIDTH(PW)) bus ();

    alu_mul_ctrl #(
        .MUL_LATENCY(L), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .PC_WIDTH(PW), .CNT_WIDTH(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        bus.mul_req_valid = 1'b0;
        bus.mul_ra_data   = '0;
        bus.mul_rb_data   = '0;
        bus.mul_rd_addr   = '0;
        bus.mul_pc        = '0;
        bus.flush         = 1'b0;
        bus.rsp_ready     = 1'b1;
    endtask

    task automatic set_req(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [AW-1:0] rd, input logic [PW-1:0] pc);
        bus.mul_req_valid = 1'b1;
        bus.mul_ra_data   = a;
        bus.mul_rb_data   = b;
        bus.mul_rd_addr   = rd;
        bus.mul_pc        = pc;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vld"},  64'(bus.rsp_valid), 64'(0));
        chk({tag, "_busy"}, 64'(bus.alu_busy), 64'(0));
        chk({tag, "_data"}, 64'(bus.rsp_data), 64'(0));
        chk({tag, "_ovf"},  64'(bus.rsp_overflow), 64'(0));
        chk({tag, "_dst"},  64'(bus.rsp_dst_reg), 64'(0));
        chk({tag, "_pc"},   64'(bus.rsp_pc), 64'(0));
    endtask

    // Issue one MUL from IDLE, measure its latency, hold it for 'stall' cycles, then take it.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [AW-1:0] rd, input logic [PW-1:0] pc,
                          input int stall, input string tag);
        logic [63:0] p;
        int n;
        int k;
        p = 64'(a) * 64'(b);
        set_req(a, b, rd, pc);
        #1;
        n = 0;
        while (!bus.mul_req_ready && n < 20) begin
            step();
            n++;
            #1;
        end
        chk({tag, "_rdy"}, 64'(bus.mul_req_ready), 64'(1));
        step();
        bus.mul_req_valid = 1'b0;
        bus.rsp_ready     = (stall == 0);
        #1;
        n = 1;
        while (!bus.rsp_valid && n < 20) begin
            chk($sformatf("%s_busy%0d", tag, n), 64'(bus.alu_busy), 64'(1));
            step();
            n++;
            #1;
        end
        chk({tag, "_lat"},  64'(n), 64'(L));
        chk({tag, "_data"}, 64'(bus.rsp_data), 64'(p[31:0]));
        chk({tag, "_ovf"},  64'(bus.rsp_overflow), 64'(p[63:32] != 32'd0));
        chk({tag, "_dst"},  64'(bus.rsp_dst_reg), 64'(rd));
        chk({tag, "_pc"},   64'(bus.rsp_pc), 64'(pc));
        k = stall;
        while (k > 0) begin
            step();
            k--;
            bus.rsp_ready = (k == 0);
            #1;
            chk({tag, "_hold_vld"},  64'(bus.rsp_valid), 64'(1));
            chk({tag, "_hold_data"}, 64'(bus.rsp_data), 64'(p[31:0]));
        end
        step();
        bus.rsp_ready = 1'b1;
        #1;
        chk({tag, "_end_vld"},  64'(bus.rsp_valid), 64'(0));
        chk({tag, "_end_busy"}, 64'(bus.alu_busy), 64'(0));
    endtask

    initial begin
        idle_in();
        #2;
        chk_reset_vals("rst");
        #20;
        reset = 1'b0;
        step();
        chk("rst_rdy", 64'(bus.mul_req_ready), 64'(1));

        // 1: basic 7*6 with rsp_ready held high
        set_req(32'd7, 32'd6, 5'd3, 32'h100);
        #1;
        chk("t1_rdy0", 64'(bus.mul_req_ready), 64'(1));
        for (int c = 1; c <= 5; c++) begin
            step();
            bus.mul_req_valid = 1'b0;
            #1;
            chk($sformatf("t1_vld_c%0d", c),  64'(bus.rsp_valid), 64'(c == 4));
            chk($sformatf("t1_busy_c%0d", c), 64'(bus.alu_busy), 64'(c <= 4));
            if (c < 4) chk($sformatf("t1_rdy_c%0d", c), 64'(bus.mul_req_ready), 64'(0));
            if (c == 4) begin
                chk("t1_data", 64'(bus.rsp_data), 64'(42));
                chk("t1_dst",  64'(bus.rsp_dst_reg), 64'(3));
                chk("t1_pc",   64'(bus.rsp_pc), 64'(32'h100));
                chk("t1_ovf",  64'(bus.rsp_overflow), 64'(0));
            end
        end

        // 2: D$ stalls in cycles 4-6
        set_req(32'd7, 32'd6, 5'd3, 32'h100);
        #1;
        for (int c = 1; c <= 8; c++) begin
            step();
            bus.mul_req_valid = 1'b0;
            bus.rsp_ready     = !(c >= 4 && c <= 6);
            #1;
            chk($sformatf("t2_vld_c%0d", c),  64'(bus.rsp_valid), 64'(c >= 4 && c <= 7));
            chk($sformatf("t2_busy_c%0d", c), 64'(bus.alu_busy), 64'(c <= 7));
            chk($sformatf("t2_rdy_c%0d", c),  64'(bus.mul_req_ready), 64'(c >= 7));
            if (c >= 4 && c <= 7) chk($sformatf("t2_data_c%0d", c), 64'(bus.rsp_data), 64'(42));
        end

        // 3: back-to-back MUL accepted in the cycle the first result is taken
        set_req(32'd7, 32'd6, 5'd3, 32'h100);
        #1;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 4) set_req(32'd3, 32'd5, 5'd9, 32'h200);
            else bus.mul_req_valid = 1'b0;
            #1;
            chk($sformatf("t3_vld_c%0d", c),  64'(bus.rsp_valid), 64'(c == 4 || c == 8));
            chk($sformatf("t3_busy_c%0d", c), 64'(bus.alu_busy), 64'(c <= 8));
            if (c == 4) begin
                chk("t3_rdy4",  64'(bus.mul_req_ready), 64'(1));
                chk("t3_data4", 64'(bus.rsp_data), 64'(42));
            end
            if (c == 8) begin
                chk("t3_data8", 64'(bus.rsp_data), 64'(15));
                chk("t3_dst8",  64'(bus.rsp_dst_reg), 64'(9));
                chk("t3_pc8",   64'(bus.rsp_pc), 64'(32'h200));
            end
        end

        // 4: flush in cycle 2 of a BUSY op, with a competing request
        set_req(32'd7, 32'd6, 5'd3, 32'h100);
        #1;
        for (int c = 1; c <= 8; c++) begin
            step();
            bus.flush = (c == 2);
            if (c == 2) set_req(32'd2, 32'd2, 5'd1, 32'h300);
            else bus.mul_req_valid = 1'b0;
            #1;
            if (c == 2) chk("t4_rdy_flush", 64'(bus.mul_req_ready), 64'(0));
            chk($sformatf("t4_vld_c%0d", c),  64'(bus.rsp_valid), 64'(0));
            chk($sformatf("t4_busy_c%0d", c), 64'(bus.alu_busy), 64'(c <= 2));
        end

        // 5: overflow boundaries
        run_op(32'hFFFF_FFFF, 32'd2, 5'd4, 32'h400, 0, "t5a");
        run_op(32'h0001_0000, 32'h0001_0000, 5'd5, 32'h404, 1, "t5b");

        // randomized operands, tags and D$ stall lengths
        for (int i = 0; i < 16; i++) begin
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) b = DW'($urandom_range(0, 255));
            run_op(a, b, 5'($urandom_range(0, 31)), $urandom,
                   int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end

        // 6: asynchronous reset mid-cycle while BUSY with cnt=2
        run_op(32'd1000, 32'd3, 5'd7, 32'h55, 0, "t6pre");
        set_req(32'd9, 32'd9, 5'd8, 32'h66);
        #1;
        step();
        bus.mul_req_valid = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("t6_async");
        #3;
        reset = 1'b0;
        step();
        chk("t6_rdy", 64'(bus.mul_req_ready), 64'(1));
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("t6_novld%0d", c), 64'(bus.rsp_valid), 64'(0));
            step();
        end
        run_op(32'd11, 32'd13, 5'd2, 32'h77, 0, "t6post");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
